// File: rtl/psg_bus_decoder.sv
// SN76489 host write port: synchronizes the async write strobe, decodes the
// latch/data byte protocol into the register file and drives READY.
module psg_bus_decoder #(
    parameter int unsigned READY_CYCLES    = 32,
    parameter bit          RESTART_ON_DATA = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we_n,
    input  logic [7:0] data,
    output logic       ready,
    output logic [9:0] tone0_freq,
    output logic [9:0] tone1_freq,
    output logic [9:0] tone2_freq,
    output logic [3:0] attn0,
    output logic [3:0] attn1,
    output logic [3:0] attn2,
    output logic [3:0] attn3,
    output logic [2:0] noise_control,
    output logic       restart_noise
);

    localparam int unsigned CW = (READY_CYCLES > 1) ? $clog2(READY_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(READY_CYCLES - 1);
    localparam logic [1:0] NOISE_CH = 2'd3;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    logic       s1, s2, s3;
    logic [2:0] sync_valid;
    logic       strobe;

    logic [1:0] latch_chan;
    logic       latch_attn;
    logic [9:0] freq [3];
    logic [3:0] attn [4];

    logic [1:0] tgt_chan;
    logic       tgt_attn;
    logic       wr_tone_lo;
    logic       wr_tone_hi;
    logic       wr_attn;
    logic       wr_noise;

    state_t        state;
    logic [CW-1:0] count;

    // sync_valid marks which stages hold real we_n samples since reset; a
    // strobe needs a genuine high in s3, so a we_n held low across reset
    // release must go high and fall again before it is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            s3         <= 1'b1;
            sync_valid <= '0;
        end else begin
            s1         <= we_n;
            s2         <= s1;
            s3         <= s2;
            sync_valid <= {sync_valid[1:0], 1'b1};
        end
    end

    assign strobe = sync_valid[2] & s3 & ~s2;

    always_comb begin
        tgt_chan   = data[7] ? data[6:5] : latch_chan;
        tgt_attn   = data[7] ? data[4]   : latch_attn;
        wr_attn    = strobe & tgt_attn;
        wr_noise   = strobe & ~tgt_attn & (tgt_chan == NOISE_CH)
                     & (data[7] | RESTART_ON_DATA);
        wr_tone_lo = strobe & ~tgt_attn & (tgt_chan != NOISE_CH) & data[7];
        wr_tone_hi = strobe & ~tgt_attn & (tgt_chan != NOISE_CH) & ~data[7];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch_chan    <= '0;
            latch_attn    <= 1'b0;
            noise_control <= '0;
            restart_noise <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) freq[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) attn[i] <= '1;
        end else begin
            restart_noise <= 1'b0;
            if (strobe && data[7]) begin
                latch_chan <= data[6:5];
                latch_attn <= data[4];
            end
            for (int unsigned i = 0; i < 3; i++) begin
                if (wr_tone_lo && tgt_chan == 2'(i)) freq[i][3:0] <= data[3:0];
                if (wr_tone_hi && tgt_chan == 2'(i)) freq[i][9:4] <= data[5:0];
            end
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_attn && tgt_chan == 2'(i)) attn[i] <= data[3:0];
            end
            if (wr_noise) begin
                noise_control <= data[2:0];
                restart_noise <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            ready <= 1'b1;
        end else if (strobe) begin
            state <= BUSY;
            count <= CNT_LOAD;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: ready <= 1'b1;
                BUSY: begin
                    if (count == '0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign tone0_freq = freq[0];
    assign tone1_freq = freq[1];
    assign tone2_freq = freq[2];
    assign attn0      = attn[0];
    assign attn1      = attn[1];
    assign attn2      = attn[2];
    assign attn3      = attn[3];

endmodule
